// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
//   Programmable interval timer for the traffic-light controller, together with
//   its configuration store for the three phase durations: base (tb),
//   extended (te) and yellow (ty).
//
//   When the sequencing FSM strobes start_timer, the block latches the selected
//   duration. It then counts that many one-second ticks, each TICK_DIV clocks
//   long, and returns a single-cycle expired pulse. A start during a run
//   restarts the count with the newly selected interval.
//
//   Optional build macro:
//     PARAM_READBACK_EN - adds the Param_Value output. Param_Value is a
//                         registered readback of the slot addressed by
//                         Param_Sel, with one cycle of latency.
// -----------------------------------------------------------------------------
module interval_timer_ctrl #(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 4,
   parameter int TB_DEF   = 6,
   parameter int TE_DEF   = 3,
   parameter int TY_DEF   = 2
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             Prog_Sync,
   input  logic [1:0]       Param_Sel,
   input  logic [CNT_W-1:0] Time_Value,
   input  logic [1:0]       interval,
   input  logic             start_timer,
   output logic             expired,
   output logic             busy,
   output logic [CNT_W-1:0] remaining,
   output logic             tick
`ifdef PARAM_READBACK_EN
   ,
   output logic [CNT_W-1:0] Param_Value
`endif
);

   // Prescaler width is just enough to hold 0..TICK_DIV-1.
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   localparam logic [1:0] SEL_TB  = 2'b00;
   localparam logic [1:0] SEL_TE  = 2'b01;
   localparam logic [1:0] SEL_TY  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_reg,     state_next;
   logic [PRE_W-1:0]   presc_reg,     presc_next;
   logic [CNT_W-1:0]   remaining_reg, remaining_next;
   logic               expired_reg,   expired_next;
   logic               tick_reg,      tick_next;

   // Current and next-cycle values of the three duration slots.
   // Index 0 = tb, 1 = te, 2 = ty.
   logic [2:0][CNT_W-1:0] slot_val;
   logic [2:0][CNT_W-1:0] slot_next;

   logic [CNT_W-1:0]   sel_duration;
   logic               presc_last;

   // -------------------------------------------------------------------------
   // Configuration store: one register per slot.
   // A programmed value of zero falls back to that slot's default, so a zero
   // duration can never be stored. Param_Sel = 11 matches no slot and is
   // therefore ignored.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         localparam logic [CNT_W-1:0] SLOT_DEF =
            (gi == 0) ? CNT_W'(TB_DEF) :
            (gi == 1) ? CNT_W'(TE_DEF) :
                        CNT_W'(TY_DEF);

         logic [CNT_W-1:0] val_reg;
         logic [CNT_W-1:0] val_next;
         logic             wr_hit;

         assign wr_hit   = Prog_Sync && (Param_Sel == 2'(gi));
         assign val_next = !wr_hit             ? val_reg  :
                           (Time_Value == '0)  ? SLOT_DEF :
                                                 Time_Value;

         // Slot register; reset restores the default duration.
         always_ff @(posedge clk or negedge Reset_n) begin
            if (!Reset_n) begin
               val_reg <= SLOT_DEF;
            end else begin
               val_reg <= val_next;
            end
         end

         assign slot_val[gi]  = val_reg;
         assign slot_next[gi] = val_next;
      end
   endgenerate

   // Duration selected by interval.
   // The current slot value is used, so a write on the same edge as a start
   // only affects later starts. Code 11 selects the base duration.
   always_comb begin
      sel_duration = slot_val[0];
      case (interval)
         SEL_TE:  sel_duration = slot_val[1];
         SEL_TY:  sel_duration = slot_val[2];
         default: sel_duration = slot_val[0];
      endcase
   end

   assign presc_last = (presc_reg == PRE_LAST);

   // -------------------------------------------------------------------------
   // Timer FSM state register.
   // Outputs are registered, so tick/expired line up with the remaining value
   // they describe.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         presc_reg     <= '0;
         remaining_reg <= '0;
         expired_reg   <= 1'b0;
         tick_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         presc_reg     <= presc_next;
         remaining_reg <= remaining_next;
         expired_reg   <= expired_next;
         tick_reg      <= tick_next;
      end
   end

   // Timer FSM next-state logic.
   // A start always wins, which silently aborts any run in progress; otherwise
   // the prescaler advances and each wrap consumes one second.
   always_comb begin
      state_next     = state_reg;
      presc_next     = presc_reg;
      remaining_next = remaining_reg;
      expired_next   = 1'b0;
      tick_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_timer) begin
               state_next     = RUN;
               presc_next     = '0;
               remaining_next = sel_duration;
            end
         end

         RUN: begin
            if (start_timer) begin
               presc_next     = '0;
               remaining_next = sel_duration;
            end else if (presc_last) begin
               presc_next = '0;
               tick_next  = 1'b1;
               // This is the final second. The <= 1 test also guards
               // against ever decrementing through zero.
               if (remaining_reg <= CNT_W'(1)) begin
                  remaining_next = '0;
                  expired_next   = 1'b1;
                  state_next     = IDLE;
               end else begin
                  remaining_next = remaining_reg - CNT_W'(1);
               end
            end else begin
               presc_next = presc_reg + PRE_W'(1);
            end
         end

         default: begin
            state_next     = IDLE;
            presc_next     = '0;
            remaining_next = '0;
         end
      endcase
   end

   assign busy      = (state_reg == RUN);
   assign expired   = expired_reg;
   assign remaining = remaining_reg;
   assign tick      = tick_reg;

`ifdef PARAM_READBACK_EN
   // Readback register.
   // It samples the slot's next value, so a write is visible in the cycle
   // after its write edge.
   logic [CNT_W-1:0] param_value_reg;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         param_value_reg <= '0;
      end else begin
         case (Param_Sel)
            SEL_TB:  param_value_reg <= slot_next[0];
            SEL_TE:  param_value_reg <= slot_next[1];
            SEL_TY:  param_value_reg <= slot_next[2];
            default: param_value_reg <= '0;
         endcase
      end
   end

   assign Param_Value = param_value_reg;
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interval_timer_ctrl
//   Scoreboard bench for interval_timer_ctrl with TICK_DIV = 4.
//   Each start pushes the expected expiry cycle and duration. The monitor pops
//   an entry on every expired pulse and checks the cycle, the tick count and
//   the busy level.
//   Build with PARAM_READBACK_EN defined to exercise the readback port.
// -----------------------------------------------------------------------------
module tb_interval_timer_ctrl;

   localparam int TD = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          Reset_n;
   logic          Prog_Sync;
   logic [1:0]    Param_Sel;
   logic [CW-1:0] Time_Value;
   logic [1:0]    interval;
   logic          start_timer;
   logic          expired;
   logic          busy;
   logic [CW-1:0] remaining;
   logic          tick;
`ifdef PARAM_READBACK_EN
   logic [CW-1:0] Param_Value;
`endif

   interval_timer_ctrl #(
      .TICK_DIV(TD), .CNT_W(CW), .TB_DEF(6), .TE_DEF(3), .TY_DEF(2)
   ) dut (
      .clk(clk), .Reset_n(Reset_n), .Prog_Sync(Prog_Sync),
      .Param_Sel(Param_Sel), .Time_Value(Time_Value),
      .interval(interval), .start_timer(start_timer),
      .expired(expired), .busy(busy), .remaining(remaining), .tick(tick)
`ifdef PARAM_READBACK_EN
      , .Param_Value(Param_Value)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int n;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   errors   = 0;
   int   checks   = 0;
   int   tick_cnt = 0;
   int   cur_n    = 0;
   int   dflt[3]  = '{6, 3, 2};
   int   model[3] = '{6, 3, 2};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Monitor, sampling on the falling edge.
   // All stimulus is applied at negedge+1, so it never races this block.
   always @(negedge clk) begin
      if (tick) begin
         tick_cnt++;
         check_val("remaining_at_tick", int'(remaining), cur_n - tick_cnt);
      end
      if (expired) begin
         if (sb.size() == 0) begin
            check_val("spurious_expired", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("expired at cycle %0d (expected %0d, n=%0d)", cyc, e.cyc, e.n);
            check_val("expire_cycle", cyc, e.cyc);
            check_val("tick_count", tick_cnt, e.n);
            check_val("busy_low_at_expire", int'(busy), 0);
         end
      end
   end

   // Program one slot for a single cycle and update the reference model.
   task automatic do_prog(input int sel, input int val);
      Prog_Sync  = 1'b1;
      Param_Sel  = 2'(sel);
      Time_Value = CW'(val);
      @(negedge clk);
      if (sel < 3) model[sel] = (val == 0) ? dflt[sel] : val;
      $display("prog sel=%0d val=%0d", sel, val);
`ifdef PARAM_READBACK_EN
      check_val("readback", int'(Param_Value), (sel < 3) ? model[sel] : 0);
`endif
      #1 Prog_Sync = 1'b0;
   endtask

   // Issue a one-cycle start. When abort is set, the pending entry of the run
   // being restarted is dropped from the scoreboard.
   task automatic do_start(input int sel, input bit abort);
      int n;
      n = model[(sel == 3) ? 0 : sel];
      if (abort && sb.size() > 0) void'(sb.pop_back());
      start_timer = 1'b1;
      interval    = 2'(sel);
      sb.push_back('{cyc + 1 + n * TD, n});
      cur_n    = n;
      tick_cnt = 0;
      $display("start interval=%0d n=%0d at edge %0d", sel, n, cyc + 1);
      @(negedge clk);
      check_val("busy_after_start", int'(busy), 1);
      check_val("remaining_after_start", int'(remaining), n);
      #1 start_timer = 1'b0;
   endtask

   // Bounded wait for all expected expiries, then a short quiet window.
   // The quiet window lets the monitor catch any duplicate pulse.
   task automatic wait_done();
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      check_val("scoreboard_drained", sb.size(), 0);
      check_val("idle_busy", int'(busy), 0);
      check_val("idle_remaining", int'(remaining), 0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      Reset_n = 1'b0; Prog_Sync = 1'b0; Param_Sel = 2'b00;
      Time_Value = '0; interval = 2'b00; start_timer = 1'b0;
      #12;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_remaining", int'(remaining), 0);
      check_val("rst_expired", int'(expired), 0);
      check_val("rst_tick", int'(tick), 0);
      @(negedge clk); #1 Reset_n = 1'b1;
      repeat (2) @(negedge clk); #1;
      check_val("post_rst_busy", int'(busy), 0);

      // Default base duration: 24 cycles.
      do_start(0, 0);
      wait_done();

      // Program te = 9, then run te (36 cycles) and tb (still 24 cycles).
      do_prog(1, 9);
      do_start(1, 0);
      wait_done();
      do_start(0, 0);
      wait_done();

      // A zero write keeps the default ty = 2; a write to slot 11 is ignored.
      do_prog(2, 0);
      do_start(2, 0);
      wait_done();
      do_prog(3, 7);
      do_start(0, 0);
      wait_done();

      // Restart after 10 cycles with ty: a single expiry 8 cycles later.
      do_start(0, 0);
      repeat (9) @(negedge clk); #1;
      do_start(2, 1);
      wait_done();

      // Reset mid-run: no expiry, and the programmed te reverts to 3.
      do_start(0, 0);
      e0 = cyc;
      while (cyc < e0 + 12) @(negedge clk);
      #1;
      sb.delete();
      Reset_n = 1'b0;
      model = dflt;
      #1;
      check_val("midrun_rst_busy", int'(busy), 0);
      check_val("midrun_rst_remaining", int'(remaining), 0);
      check_val("midrun_rst_expired", int'(expired), 0);
      repeat (3) @(negedge clk);
      #1 Reset_n = 1'b1;
      do_start(1, 0);
      wait_done();

      // Write and start on the same tb slot in one cycle: the start uses the
      // old value (24 cycles) and the next start uses the new value (4).
      Prog_Sync = 1'b1; Param_Sel = 2'b00; Time_Value = CW'(1);
      do_start(0, 0);
      Prog_Sync = 1'b0;
      model[0] = 1;
      wait_done();
      do_start(0, 0);
      wait_done();
      do_prog(0, 0);

      // interval = 11 selects tb. A start issued during the expiry cycle
      // begins a fresh 24-cycle run.
      do_start(3, 0);
      e0 = sb[0].cyc;
      while (cyc < e0) @(negedge clk);
      #1;
      check_val("expired_in_expiry_cycle", int'(expired), 1);
      do_start(0, 0);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Programmable interval timer and its configuration store for the traffic-light controller.
- Holds the three phase durations (base tb, extended te, yellow ty) and accepts run-time reprogramming.
- On a start request from the light-sequencing FSM, counts the selected duration in seconds and returns a one-cycle expired pulse.
- Sits between the sequencing FSM (interval, start_timer, expired) and the synchronised program inputs.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick; must be >= 2.
- CNT_W, 4, width of duration values and the countdown.
- TB_DEF, 6, reset/default base duration in seconds.
- TE_DEF, 3, reset/default extended duration in seconds.
- TY_DEF, 2, reset/default yellow duration in seconds.

Ports:
- clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Prog_Sync  in  1  synchronised program strobe, one cycle
- Param_Sel  in  2  slot to program: 00 tb, 01 te, 10 ty, 11 reserved
- Time_Value  in  CNT_W  new duration in seconds
- interval  in  2  duration select for the start: 00 tb, 01 te, 10 ty, 11 treated as tb
- start_timer  in  1  start/restart strobe from the FSM
- expired  out  1  one-cycle pulse at the end of the interval
- busy  out  1  high while a countdown is active
- remaining  out  CNT_W  whole seconds left; 0 when idle
- tick  out  1  one-cycle pulse per elapsed second while busy

Behaviour:
- Reset (Reset_n low, asynchronous):
  - tb/te/ty registers load TB_DEF, TE_DEF and TY_DEF.
  - Prescaler is 0; state is IDLE.
  - expired=0, busy=0, remaining=0, tick=0.
  - Release is clocked normally; no start is generated internally.
- States: IDLE and RUN.
- IDLE -> RUN:
  - Taken on the edge that samples start_timer=1.
  - Prescaler <= 0 and remaining <= selected parameter.
  - busy goes high in the next cycle.
- RUN, prescaler counting:
  - Prescaler counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0, tick pulses, and remaining decrements.
- RUN -> IDLE:
  - Taken on the tick that takes remaining from 1 to 0.
  - expired=1 for exactly one cycle and busy drops in the same cycle.
  - expired is asserted exactly N*TICK_DIV cycles after the start edge, where N is the duration latched at start.
- Restart: start_timer=1 while in RUN restarts the count from the edge of the new start, using the new interval. Start has priority over a same-cycle expiry, so no expired pulse is produced for the aborted interval.
- Start sampled in the same cycle as expired is a new start; the block re-enters RUN.
- expired is never asserted twice for one start. The sequencing FSM samples expired as a level, so the pulse must be exactly one cycle wide.
- Programming:
  - Prog_Sync=1 writes Time_Value into the Param_Sel slot on that edge.
  - Param_Sel=11 is ignored.
  - Time_Value=0 writes that slot's default value; a zero duration is never stored.
- Programming during RUN does not alter the active count; it takes effect at the next start.
- Simultaneous Prog_Sync and start_timer to the same slot: the start uses the old value and the new value is stored.
- Reset_n low mid-run aborts immediately. No expired pulse is produced and all programmed values revert to defaults.
- Width rules:
  - remaining is unsigned CNT_W bits and never wraps below 0.
  - The prescaler is sized to clog2(TICK_DIV).

Optional Feature:
- PARAM_READBACK_EN defined:
  - Adds output Param_Value (CNT_W bits).
  - Param_Value is a registered copy of the slot addressed by Param_Sel, one-cycle latency; 0 for Param_Sel=11.
  - Reflects a write on the cycle after the write edge.
- PARAM_READBACK_EN undefined: the port and its register are absent, and behaviour is otherwise identical.

Test Plan (TICK_DIV=4, defaults):
- Release reset, pulse start_timer with interval=00 -> expired exactly 24 cycles after the start edge, one cycle wide; busy high throughout; remaining steps 6..1 on each tick.
- Prog_Sync with Param_Sel=01 and Time_Value=9, then start with interval=01 -> expired at +36 cycles; a second start with interval=00 still gives +24.
- Prog_Sync with Param_Sel=10 and Time_Value=0, then start with interval=10 -> expired at +8 (default 2 retained). Prog_Sync with Param_Sel=11 -> no slot changes.
- Start with interval=00, then start with interval=10 ten cycles later -> single expired at +8 from the second start; none at +24 from the first.
- Start with interval=00, then Reset_n low at +12 -> expired never fires; busy=0 and remaining=0 immediately; programmed te reverts to 3.
- Start with interval=11 -> expired at +24 (tb). Start asserted in the expiry cycle -> a new 24-cycle run with no lost or duplicate pulse.
